// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, bridge FSM encoding, response decode.
package axi4lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StWrReq,
    StWrResp,
    StRdReq,
    StRdResp,
    StDone
  } state_e;

  // SLVERR and DECERR terminate the Wishbone cycle with err; OKAY/EXOKAY with ack.
  function automatic logic is_error(input logic [1:0] resp);
    logic err;
    unique case (resp)
      RESP_OKAY, RESP_EXOKAY: err = 1'b0;
      RESP_SLVERR, RESP_DECERR: err = 1'b1;
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/wishbone_to_axi4lite.sv
// Wishbone classic slave to AXI4-Lite master bridge, one transaction in flight.
module wishbone_to_axi4lite #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  // Wishbone slave port
  input  logic [ADDR_WIDTH-1:0]     wb_adr_i,
  input  logic [DATA_WIDTH-1:0]     wb_dat_i,
  output logic [DATA_WIDTH-1:0]     wb_dat_o,
  input  logic [DATA_WIDTH/8-1:0]   wb_sel_i,
  input  logic                      wb_we_i,
  input  logic                      wb_cyc_i,
  input  logic                      wb_stb_i,
  output logic                      wb_ack_o,
  output logic                      wb_err_o,
  output logic                      wb_rty_o,
  // AXI4-Lite master port
  output logic [ADDR_WIDTH-1:0]     axi_awaddr_o,
  output logic                      axi_awvalid_o,
  input  logic                      axi_awready_i,
  output logic [DATA_WIDTH-1:0]     axi_wdata_o,
  output logic [DATA_WIDTH/8-1:0]   axi_wstrb_o,
  output logic                      axi_wvalid_o,
  input  logic                      axi_wready_i,
  input  logic [1:0]                axi_bresp_i,
  input  logic                      axi_bvalid_i,
  output logic                      axi_bready_o,
  output logic [ADDR_WIDTH-1:0]     axi_araddr_o,
  output logic                      axi_arvalid_o,
  input  logic                      axi_arready_i,
  input  logic [DATA_WIDTH-1:0]     axi_rdata_i,
  input  logic [1:0]                axi_rresp_i,
  input  logic                      axi_rvalid_i,
  output logic                      axi_rready_o
);
  import axi4lite_pkg::*;

  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
    $error("wishbone_to_axi4lite: DATA_WIDTH must be 32 or 64");
  end

  state_e                    state_q;
  logic [ADDR_WIDTH-1:0]     adr_q;
  logic [DATA_WIDTH-1:0]     dat_q;
  logic [DATA_WIDTH/8-1:0]   sel_q;
  logic [DATA_WIDTH-1:0]     rdata_q;
  logic [1:0]                resp_q;
  logic                      awvalid_q;
  logic                      wvalid_q;
  logic                      bready_q;
  logic                      arvalid_q;
  logic                      rready_q;
  logic                      aborted_q;

  // Request capture, AXI channel sequencing and response latching.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= StIdle;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      rdata_q   <= '0;
      resp_q    <= RESP_OKAY;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (wb_cyc_i && wb_stb_i) begin
            adr_q     <= wb_adr_i;
            dat_q     <= wb_dat_i;
            sel_q     <= wb_sel_i;
            aborted_q <= 1'b0;
            if (wb_we_i) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= StWrReq;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= StRdReq;
            end
          end
        end
        StWrReq: begin
          // AW and W retire independently; a low valid means that channel is already done.
          if (awvalid_q && axi_awready_i) awvalid_q <= 1'b0;
          if (wvalid_q && axi_wready_i) wvalid_q <= 1'b0;
          if ((!awvalid_q || axi_awready_i) && (!wvalid_q || axi_wready_i)) begin
            bready_q <= 1'b1;
            state_q  <= StWrResp;
          end
        end
        StWrResp: begin
          if (axi_bvalid_i) begin
            bready_q <= 1'b0;
            resp_q   <= axi_bresp_i;
            state_q  <= StDone;
          end
        end
        StRdReq: begin
          if (axi_arready_i) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= StRdResp;
          end
        end
        StRdResp: begin
          if (axi_rvalid_i) begin
            rready_q <= 1'b0;
            rdata_q  <= axi_rdata_i;
            resp_q   <= axi_rresp_i;
            state_q  <= StDone;
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
      // The initiator gave up; finish the AXI side but suppress the termination.
      if (state_q != StIdle && !wb_cyc_i) aborted_q <= 1'b1;
    end
  end

  // Outputs are decoded from registers only, so they change just after a clock edge.
  always_comb begin
    wb_ack_o      = (state_q == StDone) && !aborted_q && !is_error(resp_q);
    wb_err_o      = (state_q == StDone) && !aborted_q && is_error(resp_q);
    wb_rty_o      = 1'b0;
    wb_dat_o      = rdata_q;
    axi_awaddr_o  = adr_q;
    axi_awvalid_o = awvalid_q;
    axi_wdata_o   = dat_q;
    axi_wstrb_o   = sel_q;
    axi_wvalid_o  = wvalid_q;
    axi_bready_o  = bready_q;
    axi_araddr_o  = adr_q;
    axi_arvalid_o = arvalid_q;
    axi_rready_o  = rready_q;
  end

endmodule

// File: tb/tb_wishbone_to_axi4lite.sv
// Scoreboarded bench: Wishbone initiator, AXI4-Lite slave model with memory, random traffic.
module tb_wishbone_to_axi4lite;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i, wb_cyc_i, wb_stb_i, wb_ack_o, wb_err_o, wb_rty_o;
  logic [31:0] axi_awaddr_o, axi_wdata_o, axi_araddr_o, axi_rdata_i;
  logic [3:0]  axi_wstrb_o;
  logic        axi_awvalid_o, axi_awready_i, axi_wvalid_o, axi_wready_i;
  logic [1:0]  axi_bresp_i, axi_rresp_i;
  logic        axi_bvalid_i, axi_bready_o, axi_arvalid_o, axi_arready_i;
  logic        axi_rvalid_i, axi_rready_o;

  wishbone_to_axi4lite #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_sel_i(wb_sel_i),
    .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_ack_o(wb_ack_o),
    .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o),
    .axi_awaddr_o(axi_awaddr_o), .axi_awvalid_o(axi_awvalid_o), .axi_awready_i(axi_awready_i),
    .axi_wdata_o(axi_wdata_o), .axi_wstrb_o(axi_wstrb_o), .axi_wvalid_o(axi_wvalid_o),
    .axi_wready_i(axi_wready_i), .axi_bresp_i(axi_bresp_i), .axi_bvalid_i(axi_bvalid_i),
    .axi_bready_o(axi_bready_o), .axi_araddr_o(axi_araddr_o), .axi_arvalid_o(axi_arvalid_o),
    .axi_arready_i(axi_arready_i), .axi_rdata_i(axi_rdata_i), .axi_rresp_i(axi_rresp_i),
    .axi_rvalid_i(axi_rvalid_i), .axi_rready_o(axi_rready_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard and expected AXI payloads
  typedef struct packed {
    logic        err;
    logic [31:0] dat;
  } sb_t;
  sb_t         sb[$];
  sb_t         mon_e;
  logic [31:0] exp_aw[$];
  logic [35:0] exp_w[$];
  logic [31:0] exp_ar[$];

  // Reference memory (what the initiator believes) and slave memory (what arrived on AXI)
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] s_mem[logic [31:0]];
  logic [31:0] last_rd = '0;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a * 32'h9E37_79B1 ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (sel[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] s_rd(input logic [31:0] a);
    return s_mem.exists(a) ? s_mem[a] : dflt(a);
  endfunction

  // Slave knobs
  int         aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;

  // Slave state
  logic        aw_fire, aw_got, w_fire, w_got, b_fire, ar_fire, ar_got, r_fire;
  int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, aw_hi, w_hi, ar_hi;
  int          b_count = 0, last_aw_cycles = 0, last_w_cycles = 0;
  logic [31:0] aw_addr_s, ar_addr_s, aw_prev, ar_prev;
  logic [35:0] w_s, w_prev;

  // AXI4-Lite slave: decides ready/valid on the falling edge; a handshake decided here
  // completes on the next rising edge.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      {axi_awready_i, axi_wready_i, axi_bvalid_i, axi_arready_i, axi_rvalid_i} = '0;
      axi_bresp_i = '0; axi_rresp_i = '0; axi_rdata_i = '0;
      {aw_fire, aw_got, w_fire, w_got, b_fire, ar_fire, ar_got, r_fire} = '0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
      aw_hi = 0; w_hi = 0; ar_hi = 0;
    end else begin
      // B channel (uses AW/W completion from earlier edges)
      if (axi_bready_o) check("bready_before_aw_w_done", {aw_got, w_got}, 2'b11);
      if (b_fire) begin
        check("bready_after_b_hs", axi_bready_o, 0);
        axi_bvalid_i = 0; b_fire = 0; aw_got = 0; w_got = 0; b_cnt = 0; b_count++;
      end else if (aw_got && w_got && !axi_bvalid_i) begin
        if (b_cnt >= b_dly) begin
          axi_bvalid_i = 1; axi_bresp_i = bresp_cfg;
          if (!bresp_cfg[1]) s_mem[aw_addr_s] = merge(s_rd(aw_addr_s), w_s[31:0], w_s[35:32]);
        end else b_cnt++;
      end
      if (axi_bvalid_i && axi_bready_o) b_fire = 1;

      // AW channel
      if (aw_fire) begin
        check("awvalid_after_hs", axi_awvalid_o, 0);
        axi_awready_i = 0; aw_fire = 0; aw_cnt = 0;
      end else if (axi_awvalid_o && aw_got) begin
        check("awvalid_repeat", axi_awvalid_o, 0);
      end else if (axi_awvalid_o) begin
        aw_hi++;
        if (aw_hi > 1) check("awaddr_stable", axi_awaddr_o, aw_prev);
        aw_prev = axi_awaddr_o;
        if (aw_cnt >= aw_dly) begin
          axi_awready_i = 1; aw_fire = 1; aw_got = 1; aw_addr_s = axi_awaddr_o;
          last_aw_cycles = aw_hi; aw_hi = 0;
          if (exp_aw.size() == 0) check("aw_expected", exp_aw.size(), 1);
          else check("awaddr", axi_awaddr_o, exp_aw.pop_front());
        end else aw_cnt++;
      end else if (aw_hi != 0) begin
        check("awvalid_held_until_hs", axi_awvalid_o, 1); aw_hi = 0;
      end

      // W channel
      if (w_fire) begin
        check("wvalid_after_hs", axi_wvalid_o, 0);
        axi_wready_i = 0; w_fire = 0; w_cnt = 0;
      end else if (axi_wvalid_o && w_got) begin
        check("wvalid_repeat", axi_wvalid_o, 0);
      end else if (axi_wvalid_o) begin
        w_hi++;
        if (w_hi > 1) check("wdata_wstrb_stable", {axi_wstrb_o, axi_wdata_o}, w_prev);
        w_prev = {axi_wstrb_o, axi_wdata_o};
        if (w_cnt >= w_dly) begin
          axi_wready_i = 1; w_fire = 1; w_got = 1; w_s = {axi_wstrb_o, axi_wdata_o};
          last_w_cycles = w_hi; w_hi = 0;
          if (exp_w.size() == 0) check("w_expected", exp_w.size(), 1);
          else check("wstrb_wdata", {axi_wstrb_o, axi_wdata_o}, exp_w.pop_front());
        end else w_cnt++;
      end else if (w_hi != 0) begin
        check("wvalid_held_until_hs", axi_wvalid_o, 1); w_hi = 0;
      end

      // R channel
      if (axi_rready_o) check("rready_before_ar_done", ar_got, 1);
      if (r_fire) begin
        check("rready_after_r_hs", axi_rready_o, 0);
        axi_rvalid_i = 0; r_fire = 0; ar_got = 0; r_cnt = 0;
      end else if (ar_got && !axi_rvalid_i) begin
        if (r_cnt >= r_dly) begin
          axi_rvalid_i = 1; axi_rdata_i = s_rd(ar_addr_s); axi_rresp_i = rresp_cfg;
        end else r_cnt++;
      end
      if (axi_rvalid_i && axi_rready_o) r_fire = 1;

      // AR channel
      if (ar_fire) begin
        check("arvalid_after_hs", axi_arvalid_o, 0);
        axi_arready_i = 0; ar_fire = 0; ar_cnt = 0;
      end else if (axi_arvalid_o && ar_got) begin
        check("arvalid_repeat", axi_arvalid_o, 0);
      end else if (axi_arvalid_o) begin
        ar_hi++;
        if (ar_hi > 1) check("araddr_stable", axi_araddr_o, ar_prev);
        ar_prev = axi_araddr_o;
        if (ar_cnt >= ar_dly) begin
          axi_arready_i = 1; ar_fire = 1; ar_got = 1; ar_addr_s = axi_araddr_o; ar_hi = 0;
          if (exp_ar.size() == 0) check("ar_expected", exp_ar.size(), 1);
          else check("araddr", axi_araddr_o, exp_ar.pop_front());
        end else ar_cnt++;
      end else if (ar_hi != 0) begin
        check("arvalid_held_until_hs", axi_arvalid_o, 1); ar_hi = 0;
      end
    end
  end

  // Monitor: every Wishbone termination consumes one scoreboard entry.
  always @(negedge clk_i) begin
    if (rst_i && (wb_ack_o || wb_err_o)) begin
      check("wb_rty", wb_rty_o, 0);
      if (sb.size() == 0) begin
        check("wb_unexpected_term", {wb_ack_o, wb_err_o}, 2'b00);
      end else begin
        mon_e = sb.pop_front();
        check("wb_ack", wb_ack_o, !mon_e.err);
        check("wb_err", wb_err_o, mon_e.err);
        check("wb_dat_o", wb_dat_o, mon_e.dat);
      end
    end
  end

  logic [2:0] v_at1;

  // Drive one Wishbone classic cycle; n_term is the cycle index of the termination.
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output int n_term);
    @(posedge clk_i); #1;
    wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel; wb_we_i = we;
    wb_cyc_i = 1; wb_stb_i = 1;
    n_term = -1; v_at1 = '0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk_i);
      if (n == 1) v_at1 = {axi_awvalid_o, axi_wvalid_o, axi_arvalid_o};
      if (wb_ack_o || wb_err_o) begin
        n_term = n;
        break;
      end
    end
    if (n_term < 0) check("wb_termination_seen", wb_ack_o | wb_err_o, 1);
    @(posedge clk_i); #1;
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
  endtask

  // Reference model: compute the expected outcome from the request, then run it.
  task automatic do_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input logic [1:0] resp, output int n_term);
    sb_t e;
    if (we) begin
      bresp_cfg = resp;
      exp_aw.push_back(adr);
      exp_w.push_back({sel, dat});
      if (!resp[1]) ref_mem[adr] = merge(ref_rd(adr), dat, sel);
    end else begin
      rresp_cfg = resp;
      exp_ar.push_back(adr);
      last_rd = ref_rd(adr);
    end
    e.err = resp[1];
    e.dat = last_rd;
    sb.push_back(e);
    wb_xfer(we, adr, dat, sel, n_term);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bc;
    logic [31:0] adr;
    logic [1:0]  resp;
    wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0; wb_we_i = 0; wb_cyc_i = 0; wb_stb_i = 0;
    repeat (3) @(negedge clk_i);
    check("reset_ctrl_outputs", {axi_awvalid_o, axi_wvalid_o, axi_bready_o, axi_arvalid_o,
                                 axi_rready_o, wb_ack_o, wb_err_o, wb_rty_o}, 8'h00);
    check("reset_wb_dat_o", wb_dat_o, 0);
    #2 rst_i = 1;

    // Minimum-latency write
    do_txn(1, 32'h10, 32'hCAFE_BABE, 4'hF, 2'b00, n);
    check("t1_ack_cycle", n, 3);
    check("t1_aw_w_valid_cycle1", v_at1, 3'b110);
    check("t1_awvalid_cycles", last_aw_cycles, 1);

    // Slow AW, immediate W
    aw_dly = 3;
    do_txn(1, 32'h20, 32'h1234_5678, 4'h5, 2'b00, n);
    aw_dly = 0;
    check("t2_awvalid_cycles", last_aw_cycles, 4);
    check("t2_wvalid_cycles", last_w_cycles, 1);
    check("t2_ack_cycle", n, 6);

    // Read with delayed R, then data hold across a write
    do_txn(1, 32'h4, 32'hDEAD_BEEF, 4'hF, 2'b00, n);
    r_dly = 2;
    do_txn(0, 32'h4, 32'h0, 4'h0, 2'b00, n);
    r_dly = 0;
    check("t3_ar_valid_cycle1", v_at1, 3'b001);
    check("t3_ack_cycle", n, 5);
    do_txn(1, 32'h8, 32'h0BAD_F00D, 4'h3, 2'b00, n);
    check("t3_dat_hold_after_write", wb_dat_o, 32'hDEAD_BEEF);

    // Error terminations
    do_txn(0, 32'h4, 32'h0, 4'h0, 2'b10, n);
    check("t4_rd_err_cycle", n, 3);
    do_txn(1, 32'hC, 32'h55AA_55AA, 4'hF, 2'b11, n);
    check("t4_wr_err_cycle", n, 3);

    // Abort during WR_REQ: AXI write still completes, no termination
    aw_dly = 4; bresp_cfg = 2'b00;
    exp_aw.push_back(32'h30);
    exp_w.push_back({4'hF, 32'hA5A5_0001});
    ref_mem[32'h30] = 32'hA5A5_0001;
    bc = b_count;
    @(posedge clk_i); #1;
    wb_adr_i = 32'h30; wb_dat_i = 32'hA5A5_0001; wb_sel_i = 4'hF; wb_we_i = 1;
    wb_cyc_i = 1; wb_stb_i = 1;
    repeat (2) @(negedge clk_i);
    @(posedge clk_i); #1;
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
    for (int i = 0; i < 50 && b_count == bc; i++) @(negedge clk_i);
    check("t5_b_handshake_done", b_count - bc, 1);
    repeat (4) @(negedge clk_i);
    aw_dly = 0;
    do_txn(0, 32'h30, 32'h0, 4'h0, 2'b00, n);
    check("t5_next_read_cycle", n, 3);

    // Asynchronous reset while waiting in RD_RESP
    r_dly = 20; rresp_cfg = 2'b00;
    exp_ar.push_back(32'h40);
    @(posedge clk_i); #1;
    wb_adr_i = 32'h40; wb_we_i = 0; wb_cyc_i = 1; wb_stb_i = 1;
    for (int i = 0; i < 20 && !axi_rready_o; i++) @(negedge clk_i);
    check("t6_reached_rd_resp", axi_rready_o, 1);
    #2 rst_i = 0;
    #1;
    check("t6_async_ctrl", {axi_awvalid_o, axi_wvalid_o, axi_bready_o, axi_arvalid_o,
                            axi_rready_o, wb_ack_o, wb_err_o, wb_rty_o}, 8'h00);
    check("t6_async_wb_dat", wb_dat_o, 0);
    check("t6_async_addr", {axi_awaddr_o, axi_araddr_o}, 64'h0);
    check("t6_async_wdata", {axi_wstrb_o, axi_wdata_o}, 36'h0);
    wb_cyc_i = 0; wb_stb_i = 0;
    last_rd = '0;
    repeat (2) @(negedge clk_i);
    #2 rst_i = 1;
    r_dly = 0;
    do_txn(0, 32'h40, 32'h0, 4'h0, 2'b00, n);
    check("t6_fresh_read_cycle", n, 3);

    // Randomized traffic over a small address window
    for (int t = 0; t < 40; t++) begin
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
      ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      adr = 32'h100 + 32'($urandom_range(0, 7)) * 4;
      resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      do_txn(1'($urandom_range(0, 1)), adr, $urandom, 4'($urandom_range(0, 15)), resp, n);
    end

    repeat (3) @(negedge clk_i);
    check("sb_drained", sb.size(), 0);
    check("axi_expect_drained", exp_aw.size() + exp_w.size() + exp_ar.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
